// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt/timer unit: Count/Compare, TI, software IP bits,
// ext_int synchronisers, Cause.IP composition and registered int_req.
module cp0_int_ctrl #(
  parameter logic [7:0]  ADDR_COUNT   = 8'h48,
  parameter logic [7:0]  ADDR_COMPARE = 8'h58,
  parameter logic [7:0]  ADDR_CAUSE   = 8'h68,
  parameter logic [31:0] COMPARE_RST  = 32'hFFFF_FFFF,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ext_int,
  input  logic        mtc0_we,
  input  logic [7:0]  cp0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [31:0] cp0_Status_data,
  input  logic        exception,
  input  logic        eret_op,
  output logic [7:0]  cp0_Cause_IP,
  output logic [31:0] cp0_Count_data,
  output logic [31:0] cp0_Compare_data,
  output logic        timer_int,
  output logic        int_req
);

  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [5:0]  ext_sync;
  logic [1:0]  sw_ip;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ti_q;
  logic        tick_q;
  logic        req_q;

  logic we_count;
  logic we_compare;
  logic we_cause;

  logic st_ie;
  logic st_exl;
  logic [7:0] st_im;
  logic unused_status;

  assign st_ie  = cp0_Status_data[0];
  assign st_exl = cp0_Status_data[1];
  assign st_im  = cp0_Status_data[15:8];
  assign unused_status = ^{cp0_Status_data[31:16],
                           cp0_Status_data[7:2]};

  assign we_count   = mtc0_we && (cp0_addr == ADDR_COUNT);
  assign we_compare = mtc0_we && (cp0_addr == ADDR_COMPARE);
  assign we_cause   = mtc0_we && (cp0_addr == ADDR_CAUSE);

  assign ext_sync = sync_q[SYNC_STAGES-1];

  assign cp0_Cause_IP = {ext_sync[5] | ti_q,
                         ext_sync[4:0],
                         sw_ip};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_int};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_ip <= 2'b00;
    end else if (we_cause) begin
      sw_ip <= mtc0_data[9:8];
    end
  end

  // Count advances on every second cycle; a write restarts the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 32'd0;
      tick_q  <= 1'b0;
    end else if (we_count) begin
      count_q <= mtc0_data;
      tick_q  <= 1'b0;
    end else begin
      if (tick_q) begin
        count_q <= count_q + 32'd1;
      end
      tick_q <= ~tick_q;
    end
  end

  // Compare write clears TI even when it coincides with a match.
  always_ff @(posedge clk) begin
    if (rst) begin
      compare_q <= COMPARE_RST;
      ti_q      <= 1'b0;
    end else if (we_compare) begin
      compare_q <= mtc0_data;
      ti_q      <= 1'b0;
    end else if (count_q == compare_q) begin
      ti_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 1'b0;
    end else begin
      req_q <= st_ie & ~st_exl
             & (|(cp0_Cause_IP & st_im))
             & ~exception & ~eret_op;
    end
  end

  assign cp0_Count_data   = count_q;
  assign cp0_Compare_data = compare_q;
  assign timer_int        = ti_q;
  assign int_req          = req_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Bench for cp0_int_ctrl: directed scenarios plus random traffic
// against a cycle-count based reference model.
module tb_cp0_int_ctrl;

  localparam int S = 2;
  localparam logic [7:0] A_CNT = 8'h48;
  localparam logic [7:0] A_CMP = 8'h58;
  localparam logic [7:0] A_CAU = 8'h68;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ext_int;
  logic        mtc0_we;
  logic [7:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic [31:0] status;
  logic        exception;
  logic        eret_op;
  logic [7:0]  ip;
  logic [31:0] cnt;
  logic [31:0] cmp;
  logic        ti;
  logic        req;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cp0_int_ctrl #(.SYNC_STAGES(S)) dut (
    .clk(clk),
    .rst(rst),
    .ext_int(ext_int),
    .mtc0_we(mtc0_we),
    .cp0_addr(cp0_addr),
    .mtc0_data(mtc0_data),
    .cp0_Status_data(status),
    .exception(exception),
    .eret_op(eret_op),
    .cp0_Cause_IP(ip),
    .cp0_Count_data(cnt),
    .cp0_Compare_data(cmp),
    .timer_int(ti),
    .int_req(req)
  );

  // Reference model: Count = value last written + half the edges since.
  logic [31:0] m_base;
  int unsigned m_age;
  logic [31:0] m_cmp;
  logic        m_ti;
  logic        m_req;
  logic [1:0]  m_sw;
  logic [5:0]  m_hist[$];

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_age / 2);
  endfunction

  function automatic logic [7:0] m_ip();
    logic [5:0] e;
    e = m_hist[S-1];
    return {e[5] | m_ti, e[4:0], m_sw};
  endfunction

  task automatic step();
    logic [31:0] c;
    logic [7:0]  p;
    logic wcnt, wcmp, wcau;
    c = m_count();
    p = m_ip();
    wcnt = mtc0_we && cp0_addr == A_CNT;
    wcmp = mtc0_we && cp0_addr == A_CMP;
    wcau = mtc0_we && cp0_addr == A_CAU;
    if (rst) begin
      m_base = 0; m_age = 0; m_cmp = 32'hFFFF_FFFF;
      m_ti = 0; m_req = 0; m_sw = 0;
      m_hist = {};
      repeat (S) m_hist.push_back(6'd0);
    end else begin
      m_req = status[0] && !status[1] && ((p & status[15:8]) != 0)
              && !exception && !eret_op;
      if (wcmp) m_ti = 0;
      else if (c == m_cmp) m_ti = 1;
      if (wcmp) m_cmp = mtc0_data;
      if (wcnt) begin
        m_base = mtc0_data;
        m_age = 0;
      end else begin
        m_age++;
      end
      if (wcau) m_sw = mtc0_data[9:8];
      m_hist.push_front(ext_int);
      void'(m_hist.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    mtc0_we = 1; cp0_addr = a; mtc0_data = d;
    step();
    mtc0_we = 0; cp0_addr = 0; mtc0_data = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    rst = 0;
    repeat (10) step();
    total++;
    if (cnt !== 32'd5) begin
      bad++; $display("FAIL reset_count got=%h exp=%h", cnt, 32'd5);
    end
    total++;
    if (cmp !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL reset_compare got=%h exp=ffffffff", cmp);
    end
    total++;
    if (ip !== 8'h00 || ti !== 1'b0 || req !== 1'b0) begin
      bad++; $display("FAIL reset_flags ip=%h ti=%b req=%b exp 0", ip, ti, req);
    end
  endtask

  task automatic test_timer();
    int n;
    status = 32'h0000_8001;
    mtc0(A_CNT, 32'h10);
    mtc0(A_CMP, 32'h14);
    n = 0;
    while (!m_ti && n < 40) begin
      step();
      n++;
    end
    total++;
    if (ti !== 1'b1 || !m_ti) begin
      bad++; $display("FAIL timer_set ti=%b model=%b exp=1", ti, m_ti);
    end
    total++;
    if (ip[7] !== 1'b1 || cnt !== m_count()) begin
      bad++; $display("FAIL timer_ip7 ip=%h cnt=%h exp_cnt=%h", ip, cnt, m_count());
    end
    step();
    total++;
    if (req !== 1'b1) begin
      bad++; $display("FAIL timer_req got=%b exp=1", req);
    end
    mtc0(A_CMP, 32'h0);
    total++;
    if (ti !== 1'b0 || ip[7] !== 1'b0) begin
      bad++; $display("FAIL timer_clear ti=%b ip7=%b exp 0", ti, ip[7]);
    end
  endtask

  task automatic test_wrap();
    status = 32'h0;
    mtc0(A_CNT, 32'hFFFF_FFFF);
    repeat (2) step();
    total++;
    if (cnt !== 32'h0) begin
      bad++; $display("FAIL count_wrap got=%h exp=00000000", cnt);
    end
    if (m_age % 2 == 0) step();
    mtc0(A_CNT, 32'h0000_1234);
    total++;
    if (cnt !== 32'h0000_1234) begin
      bad++; $display("FAIL count_write_wins got=%h exp=00001234", cnt);
    end
    step();
    total++;
    if (cnt !== 32'h0000_1234) begin
      bad++; $display("FAIL count_write_hold got=%h exp=00001234", cnt);
    end
  endtask

  task automatic test_ext();
    status = 32'h0000_1001;
    ext_int = 6'b000100;
    step();
    total++;
    if (ip[4] !== 1'b0) begin
      bad++; $display("FAIL ext_early got=%b exp=0", ip[4]);
    end
    step();
    total++;
    if (ip[4] !== 1'b1) begin
      bad++; $display("FAIL ext_sync got=%b exp=1", ip[4]);
    end
    step();
    total++;
    if (req !== 1'b1) begin
      bad++; $display("FAIL ext_req got=%b exp=1", req);
    end
    status = 32'h0000_1003;
    step();
    total++;
    if (req !== 1'b0) begin
      bad++; $display("FAIL ext_exl got=%b exp=0", req);
    end
    status = 32'h0000_1001;
    step();
    exception = 1;
    step();
    exception = 0;
    total++;
    if (req !== 1'b0) begin
      bad++; $display("FAIL ext_exception got=%b exp=0", req);
    end
    step();
    total++;
    if (req !== 1'b1) begin
      bad++; $display("FAIL ext_reeval got=%b exp=1", req);
    end
    ext_int = 6'b0;
    repeat (3) step();
  endtask

  task automatic test_swint();
    status = 32'h0000_0201;
    mtc0(A_CAU, 32'h0000_0200);
    total++;
    if (ip[1] !== 1'b1) begin
      bad++; $display("FAIL sw_ip got=%b exp=1", ip[1]);
    end
    step();
    total++;
    if (req !== 1'b1) begin
      bad++; $display("FAIL sw_req got=%b exp=1", req);
    end
    mtc0(A_CAU, 32'h0);
    total++;
    if (ip[1] !== 1'b0 || req !== 1'b1) begin
      bad++; $display("FAIL sw_clear ip1=%b req=%b exp 0/1", ip[1], req);
    end
    step();
    total++;
    if (req !== 1'b0) begin
      bad++; $display("FAIL sw_req_off got=%b exp=0", req);
    end
  endtask

  task automatic test_reset_mid();
    status = 32'h0000_8001;
    ext_int = 6'b100000;
    mtc0(A_CMP, m_count() + 32'd2);
    repeat (8) step();
    total++;
    if (ti !== 1'b1 || req !== 1'b1 || cnt == 32'd0) begin
      bad++; $display("FAIL pre_reset ti=%b req=%b cnt=%h", ti, req, cnt);
    end
    rst = 1;
    step();
    rst = 0;
    total++;
    if (cnt !== 0 || cmp !== 32'hFFFF_FFFF || ip !== 0 || ti !== 0 || req !== 0) begin
      bad++;
      $display("FAIL mid_reset cnt=%h cmp=%h ip=%h ti=%b req=%b", cnt, cmp, ip, ti, req);
    end
    step();
    total++;
    if (ip[7] !== 1'b0) begin
      bad++; $display("FAIL resync_early got=%b exp=0", ip[7]);
    end
    step();
    total++;
    if (ip[7] !== 1'b1) begin
      bad++; $display("FAIL resync got=%b exp=1", ip[7]);
    end
    ext_int = 0;
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 150) == 0;
      if ($urandom % 8 == 0) ext_int = 6'($urandom);
      if ($urandom % 10 == 0) begin
        status = {16'h0, 8'($urandom), 6'h0,
                  1'(($urandom % 4) == 0), 1'($urandom)};
      end
      exception = ($urandom % 16) == 0;
      eret_op = ($urandom % 16) == 0;
      mtc0_we = ($urandom % 4) == 0;
      case ($urandom % 4)
        0: a = A_CNT;
        1: a = A_CMP;
        2: a = A_CAU;
        default: a = 8'($urandom);
      endcase
      cp0_addr = a;
      mtc0_data = (a == A_CMP) ? m_count() + 32'($urandom % 6) : $urandom;
      step();
      total++;
      if (cnt !== m_count() || cmp !== m_cmp) begin
        bad++;
        $display("FAIL rnd_cc i=%0d cnt=%h/%h cmp=%h/%h", i, cnt, m_count(), cmp, m_cmp);
      end
      total++;
      if (ip !== m_ip() || ti !== m_ti || req !== m_req) begin
        bad++;
        $display("FAIL rnd_int i=%0d ip=%h/%h ti=%b/%b req=%b/%b",
                 i, ip, m_ip(), ti, m_ti, req, m_req);
      end
    end
    rst = 0; mtc0_we = 0; exception = 0; eret_op = 0;
  endtask

  initial begin
    rst = 1; ext_int = 0; mtc0_we = 0; cp0_addr = 0;
    mtc0_data = 0; status = 0; exception = 0; eret_op = 0;
    m_hist = {};
    repeat (S) m_hist.push_back(6'd0);
    m_base = 0; m_age = 0; m_cmp = 32'hFFFF_FFFF;
    m_ti = 0; m_req = 0; m_sw = 0;
    #2;
    test_reset();
    test_timer();
    test_wrap();
    test_ext();
    test_swint();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
